// File: rtl/matproc_pkg.sv
// Shared types and constants for the matrix-processing datapath.
// Controller states, element width and drain-length helper.
package matproc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int DATA_W = 8;

  // Cycles after the last read until the last product lands in the far corner PE
  function automatic int drain_cycles(int size, int rd_lat, int mac_lat);
    return rd_lat + 2 * (size - 1) + mac_lat;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Command, operand-RAM and array-boundary signals of the systolic sequencer.
// master = sequencer side, slave = environment (host, RAMs, array).
interface systolic_ctrl_if
  import matproc_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 8
);

  logic                     start;
  logic [ADDR_W:0]          k_len;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [SIZE*DATA_W-1:0]   a_rd_data;
  logic [SIZE*DATA_W-1:0]   b_rd_data;
  logic [SIZE*DATA_W-1:0]   a_in;
  logic [SIZE*DATA_W-1:0]   b_in;
  logic                     load_en;
  logic                     mult_en;
  logic                     acc_en;

  modport master (
    input  start, k_len, a_rd_data, b_rd_data,
    output busy, done, rd_en, rd_addr,
    output a_in, b_in, load_en, mult_en, acc_en
  );

  modport slave (
    output start, k_len, a_rd_data, b_rd_data,
    input  busy, done, rd_en, rd_addr,
    input  a_in, b_in, load_en, mult_en, acc_en
  );

endinterface

// File: rtl/skew_line.sv
// Fixed-depth shift register with synchronous clear.
// Used for the read-valid delay and the per-lane diagonal skew.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for a SIZE x SIZE MAC array: clear, stream, skew, drain, done.
// Operands are zero-gated outside valid slots so padding adds nothing.
module systolic_ctrl
  import matproc_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input logic             clk,
  input logic             reset,
  systolic_ctrl_if.master bus
);

  localparam int D   = drain_cycles(SIZE, RD_LAT, MAC_LAT);
  localparam int DCW = $clog2(D + 1);
  localparam int CW  = ADDR_W + 1;

  ctrl_state_t     state, nxt;
  logic [CW-1:0]   k_q;
  logic [CW-1:0]   cnt;
  logic [DCW-1:0]  dcnt;
  logic            rd_en, load_en, mac_en, done;
  logic            vld;

  logic [SIZE*DATA_W-1:0] a_sk, b_sk;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)                          k_q <= '0;
    else if (state == IDLE && bus.start) k_q <= bus.k_len;
  end

  // Counter is ADDR_W+1 wide so K = 2**ADDR_W is representable
  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (state == CLEAR)   cnt <= '0;
    else if (state == STREAM)  cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      dcnt <= '0;
    else if (state != DRAIN && nxt == DRAIN)
      dcnt <= DCW'(D - 1);
    else if (state == DRAIN)
      dcnt <= dcnt - DCW'(1);
  end

  always_comb begin
    nxt     = state;
    rd_en   = 1'b0;
    load_en = 1'b0;
    mac_en  = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) nxt = CLEAR;
      end
      CLEAR: begin
        load_en = 1'b1;
        nxt     = (k_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        rd_en  = 1'b1;
        mac_en = 1'b1;
        if (cnt == k_q - CW'(1)) nxt = DRAIN;
      end
      DRAIN: begin
        mac_en = 1'b1;
        if (dcnt == '0) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  skew_line #(.DEPTH(RD_LAT), .W(1)) u_vld (
    .clk   (clk),
    .reset (reset),
    .d     (rd_en),
    .q     (vld)
  );

  for (genvar r = 0; r < SIZE; r++) begin : g_lane
    logic [DATA_W-1:0] a_g, b_g;

    assign a_g = vld ? bus.a_rd_data[r*DATA_W +: DATA_W] : '0;
    assign b_g = vld ? bus.b_rd_data[r*DATA_W +: DATA_W] : '0;

    skew_line #(.DEPTH(r + 1), .W(DATA_W)) u_a (
      .clk   (clk),
      .reset (reset),
      .d     (a_g),
      .q     (a_sk[r*DATA_W +: DATA_W])
    );

    skew_line #(.DEPTH(r + 1), .W(DATA_W)) u_b (
      .clk   (clk),
      .reset (reset),
      .d     (b_g),
      .q     (b_sk[r*DATA_W +: DATA_W])
    );
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = cnt[ADDR_W-1:0];
  assign bus.load_en = load_en;
  assign bus.mult_en = mac_en;
  assign bus.acc_en  = mac_en;
  assign bus.a_in    = a_sk;
  assign bus.b_in    = b_sk;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: RAM and PE-array models, matrix-product reference.
// Random and directed jobs, reset mid-job, back-to-back starts.
module tb_systolic_ctrl;

  localparam int SZ      = 4;
  localparam int AW      = 8;
  localparam int RD_LAT  = 1;
  localparam int MAC_LAT = 1;
  localparam int D       = RD_LAT + 2 * (SZ - 1) + MAC_LAT;
  localparam int KMAX    = 1 << AW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.SIZE(SZ), .ADDR_W(AW)) bus ();

  systolic_ctrl #(
    .SIZE    (SZ),
    .ADDR_W  (AW),
    .RD_LAT  (RD_LAT),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Operand memories: am[r][k] = A[r][k], bm[k][c] = B[k][c]
  logic [7:0] am [SZ][KMAX];
  logic [7:0] bm [KMAX][SZ];

  always_ff @(posedge clk) begin
    if (bus.rd_en) begin
      for (int r = 0; r < SZ; r++) begin
        bus.a_rd_data[r*8 +: 8] <= am[r][bus.rd_addr];
        bus.b_rd_data[r*8 +: 8] <= bm[bus.rd_addr][r];
      end
    end
  end

  // Output-stationary PE array: a moves right, b moves down
  logic [7:0]  pa [SZ][SZ];
  logic [7:0]  pb [SZ][SZ];
  logic [7:0]  av [SZ][SZ];
  logic [7:0]  bv [SZ][SZ];
  logic [31:0] acc [SZ][SZ];

  always_comb begin
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) begin
        av[i][j] = (j == 0) ? bus.a_in[i*8 +: 8] : pa[i][(j == 0) ? 0 : j - 1];
        bv[i][j] = (i == 0) ? bus.b_in[j*8 +: 8] : pb[(i == 0) ? 0 : i - 1][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) begin
        pa[i][j] <= av[i][j];
        pb[i][j] <= bv[i][j];
        if (bus.load_en)
          acc[i][j] <= '0;
        else if (bus.mult_en && bus.acc_en)
          acc[i][j] <= acc[i][j] + {24'b0, av[i][j]} * {24'b0, bv[i][j]};
      end
    end
  end

  // Column k is read in job cycle 2+k, arrives RD_LAT later, then 1+r stages
  function automatic logic [7:0] exp_a(int r, int n, int k);
    int idx;
    idx = n - (2 + RD_LAT + 1 + r);
    if (idx >= 0 && idx < k) return am[r][idx];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_b(int c, int n, int k);
    int idx;
    idx = n - (2 + RD_LAT + 1 + c);
    if (idx >= 0 && idx < k) return bm[idx][c];
    return 8'h00;
  endfunction

  task automatic fill(input int mode, input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < SZ; r++) begin
        unique case (mode)
          0: begin
            am[r][kk] = 8'($urandom_range(0, 255));
            bm[kk][r] = 8'($urandom_range(0, 255));
          end
          1: begin
            am[r][kk] = 8'(4 * r + kk + 1);
            bm[kk][r] = (kk == r) ? 8'd1 : 8'd0;
          end
          2: begin
            am[r][kk] = 8'(r + 1);
            bm[kk][r] = 8'(r + 1);
          end
          default: begin
            am[r][kk] = 8'hFF;
            bm[kk][r] = 8'hFF;
          end
        endcase
      end
    end
  endtask

  int fa0, fa3;
  logic [7:0] va0, va3;

  task automatic run_job(input string nm, input int k);
    int exp_done, done_n, loads, load_n, rds, addr_bad;
    int macs, busy_bad, a_bad, b_bad;
    longint e;
    exp_done = (k == 0) ? 2 : 2 + k + D;
    done_n = -1; loads = 0; load_n = -1; rds = 0; addr_bad = 0;
    macs = 0; busy_bad = 0; a_bad = 0; b_bad = 0;
    fa0 = -1; fa3 = -1; va0 = 0; va3 = 0;
    @(negedge clk);
    chk({nm, ".idle"}, {63'b0, bus.busy}, 64'd0);
    bus.start = 1'b1;
    bus.k_len = 9'(k);
    for (int n = 1; n <= exp_done + 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        bus.k_len = 9'($urandom_range(0, 511));
      end
      if (bus.load_en) begin loads++; load_n = n; end
      if (bus.rd_en) begin
        if (bus.rd_addr != 8'(rds)) addr_bad++;
        rds++;
      end
      if (bus.mult_en && bus.acc_en) macs++;
      if (!bus.busy) busy_bad++;
      for (int r = 0; r < SZ; r++) begin
        if (bus.a_in[r*8 +: 8] != exp_a(r, n, k)) a_bad++;
        if (bus.b_in[r*8 +: 8] != exp_b(r, n, k)) b_bad++;
      end
      if (fa0 < 0 && bus.a_in[7:0] != 0) begin fa0 = n; va0 = bus.a_in[7:0]; end
      if (fa3 < 0 && bus.a_in[31:24] != 0) begin fa3 = n; va3 = bus.a_in[31:24]; end
      if (bus.done) begin done_n = n; break; end
    end
    chk({nm, ".done_cycle"}, 64'(done_n), 64'(exp_done));
    chk({nm, ".load_cnt"}, 64'(loads), 64'd1);
    chk({nm, ".load_cycle"}, 64'(load_n), 64'd1);
    chk({nm, ".rd_cnt"}, 64'(rds), 64'(k));
    chk({nm, ".rd_addr_seq"}, 64'(addr_bad), 64'd0);
    chk({nm, ".mac_cycles"}, 64'(macs), (k == 0) ? 64'd0 : 64'(k + D));
    chk({nm, ".busy"}, 64'(busy_bad), 64'd0);
    chk({nm, ".a_skew"}, 64'(a_bad), 64'd0);
    chk({nm, ".b_skew"}, 64'(b_bad), 64'd0);
    for (int i = 0; i < SZ; i++) begin
      for (int j = 0; j < SZ; j++) begin
        e = 0;
        for (int kk = 0; kk < k; kk++) e += longint'(am[i][kk]) * longint'(bm[kk][j]);
        chk($sformatf("%s.d_out[%0d][%0d]", nm, i, j), 64'(acc[i][j]), 64'(e));
      end
    end
    @(negedge clk);
    chk({nm, ".busy_after"}, {63'b0, bus.busy}, 64'd0);
    chk({nm, ".done_after"}, {63'b0, bus.done}, 64'd0);
  endtask

  task automatic reset_test();
    int dn;
    dn = 0;
    fill(0, 20);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 9'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst.in_stream", {63'b0, bus.rd_en}, 64'd1);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    chk("rst.busy", {63'b0, bus.busy}, 64'd0);
    chk("rst.enables", {60'b0, bus.rd_en, bus.load_en, bus.mult_en, bus.acc_en}, 64'd0);
    chk("rst.a_in", 64'(bus.a_in), 64'd0);
    chk("rst.b_in", 64'(bus.b_in), 64'd0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      dn += int'(bus.done) + int'(bus.busy);
    end
    chk("rst.no_done", 64'(dn), 64'd0);
  endtask

  task automatic hold_start_test();
    int dones, loads, d1, d2, l2;
    dones = 0; loads = 0; d1 = -1; d2 = -1; l2 = -1;
    fill(0, 2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 9'd2;
    for (int m = 1; m <= 60; m++) begin
      @(negedge clk);
      if (bus.load_en) begin
        loads++;
        if (loads == 2) l2 = m;
      end
      if (bus.done) begin
        dones++;
        if (dones == 1) d1 = m;
        if (dones == 2) begin d2 = m; bus.start = 1'b0; end
      end
    end
    bus.start = 1'b0;
    chk("hold.done_cnt", 64'(dones), 64'd2);
    chk("hold.load_cnt", 64'(loads), 64'd2);
    chk("hold.clear_gap", 64'(l2 - d1), 64'd2);
    chk("hold.job_gap", 64'(d2 - d1), 64'(1 + 2 + 2 + D));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.k_len = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {63'b0, bus.busy}, 64'd0);
    chk("reset.done", {63'b0, bus.done}, 64'd0);
    chk("reset.enables", {60'b0, bus.rd_en, bus.load_en, bus.mult_en, bus.acc_en}, 64'd0);
    chk("reset.rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("reset.a_in", 64'(bus.a_in), 64'd0);
    chk("reset.b_in", 64'(bus.b_in), 64'd0);
    reset = 1'b0;

    fill(1, 4);
    run_job("ident", 4);

    fill(2, 1);
    run_job("skew", 1);
    chk("skew.a0_val", 64'(va0), 64'd1);
    chk("skew.a3_val", 64'(va3), 64'd4);
    chk("skew.a3_lag", 64'(fa3 - fa0), 64'd3);

    run_job("k0", 0);

    reset_test();
    fill(1, 4);
    run_job("after_rst", 4);

    hold_start_test();

    for (int j = 0; j < 6; j++) begin
      int k;
      k = $urandom_range(1, 24);
      fill(0, k);
      run_job($sformatf("rnd%0d", j), k);
    end

    fill(3, KMAX);
    run_job("ones", KMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
